// File: rtl/uart_pkg.sv
// Shared types and helpers for the serial transmitter: FSM state encoding,
// parity mode codes and counter-width / parity helper functions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Words up to nine bits are zero-extended by the caller before reduction.
  function automatic logic parity9(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts clk cycles while enabled and pulses tick in the
// final cycle of each serial bit; clears whenever disabled.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next baud count: clear when idle, wrap on the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Baud count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready host interface, start + LSB-first data +
// optional parity + stop bit(s) on a registered, idle-high serial line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy
);

  localparam int            BW        = cnt_width(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_out_q, tx_out_d;
  logic                 busy_q;
  logic                 tick;
  logic                 last_stop;
  logic                 accept;
  logic                 par_calc;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_q),
    .tick (tick)
  );

  assign last_stop = (state_q == STOP) && tick && (stop_q == STOP_LAST);
  assign tx_ready  = (state_q == IDLE) || last_stop;
  assign accept    = tx_valid && tx_ready;
  // Parity comes from the word as presented, before any shifting.
  assign par_calc  = parity9(9'(tx_data)) ^ (PARITY == PAR_ODD);

  // Frame sequencing and next line level.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    par_d    = par_q;
    tx_out_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = tx_data;
          par_d   = par_calc;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (!tick) begin
          state_d = DATA;
        end else if (bit_q == LAST_BIT) begin
          bit_d   = '0;
          state_d = (PARITY != PAR_NONE) ? PAR : STOP;
        end else begin
          bit_d   = bit_q + BW'(1);
          shift_d = shift_q >> 1;
        end
      end
      PAR: begin
        if (tick) begin
          state_d = STOP;
        end else begin
          state_d = PAR;
        end
      end
      STOP: begin
        if (!tick) begin
          state_d = STOP;
        end else if (stop_q != STOP_LAST) begin
          stop_d = stop_q + 1'b1;
        end else if (accept) begin
          stop_d  = 1'b0;
          state_d = START;
          shift_d = tx_data;
          par_d   = par_calc;
        end else begin
          stop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The line register is loaded with the level of the state being entered.
    case (state_d)
      IDLE:    tx_out_d = 1'b1;
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      PAR:     tx_out_d = par_d;
      STOP:    tx_out_d = 1'b1;
      default: tx_out_d = 1'b1;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      par_q    <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      par_q    <= par_d;
      tx_out_q <= tx_out_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign tx_out = tx_out_q;
  assign busy   = busy_q;

endmodule
